aliens_bus_ctrl: RTL and testbench
==================================

Name: aliens_bus_ctrl

Overview:
Address decoder and DTAC wait-state generator for the Aliens main CPU (Konami-2) bus. It replaces the two decode PALs and three handshake flops with single-clock synchronous RTL.
- Decodes A[15:3] into active-low memory and peripheral selects.
- Generates the active-low DTAC acknowledge.
- DTAC is fast for ROM, RAM, palette and I/O cycles.
- DTAC waits for video-chip (CKE/CKQ) phase alignment on K052109/K051960 cycles.

Parameters:
none (the memory map is fixed; its constants live in a package)

Ports:
SYSCLK   in  1   master clock; every flop is on its rising edge
nRESET   in  1   asynchronous active-low reset
CK12_CE  in  1   1-SYSCLK strobe on the 12 MHz rising edge
NCK12_CE in  1   1-SYSCLK strobe on the 12 MHz falling edge
CKQ_CE   in  1   1-SYSCLK strobe on the CKQ rising edge
CKE      in  1   CPU E-phase level
CKQ      in  1   CPU Q-phase level
AS       in  1   CPU address strobe, active low
ADRF3    in  13  CPU address A[15:3]; ADRF3[12] = A15
BK4      in  1   bank-0 select: 1 = palette, 0 = work RAM
INIT     in  1   active-high init; suppresses all selects
WOCO     in  1   work-RAM enable, active high
RMRD     in  1   video ROM-read mode
PROG     out 1   program ROM select, active low
BANK     out 1   banked ROM select, active low
WORK     out 1   work RAM select, active low
CRAMCS   out 1   palette RAM select, active low
VRAMCS   out 1   K052109 select, active low
OBJCS    out 1   K051960/K051937 select, active low
IOCS     out 1   I/O select, active low
DTAC     out 1   data acknowledge, active low

Behaviour:
Decode (combinational). Every select is low only when AS=0, INIT=0 and the address matches; otherwise it is high.
- PROG: A15=1 (0x8000-0xFFFF).
- BANK: 0x2000-0x3FFF.
- Bank-0 window 0x0000-0x03FF: CRAMCS when BK4=1; WORK when BK4=0 and WOCO=1.
- WORK: 0x0400-0x1FFF when WOCO=1.
- IOCS: 0x5F80-0x5F9F.
- OBJCS: 0x7800-0x7807 or 0x7C00-0x7FFF, only when RMRD=0.
- VRAMCS: rest of 0x4000-0x7FFF, excluding the IOCS range and any OBJCS range. With RMRD=1 the whole video window except I/O goes to VRAMCS.

Internal region flags:
- fast_n = 0 when AS=0 and the address is outside 0x4000-0x7FFF. This holds even when the select is suppressed by WOCO=0 or INIT=1, so no cycle can hang.
- vid_n = 0 when AS=0, the address is in 0x4000-0x7FFF and IOCS=1.

Handshake flops:
- All three reset to 1 on nRESET=0 (asynchronous).
- All are synchronously forced to 1 on any SYSCLK edge with AS=1.
- s1: on CKQ_CE, s1 <= vid_n.
- s2: on CK12_CE, s2 <= fast_n & IOCS.
- vrdy_n = s1 | vid_n.
- d_next = s2 & (~(CKE & CKQ) | vrdy_n).
- dtac_q: on NCK12_CE, dtac_q <= d_next.
- DTAC = dtac_q | AS. Release is immediate when AS rises.

DTAC latency:
- Fast and I/O cycles: first CK12_CE after AS falls, then the next NCK12_CE.
- Video cycles: s1 must capture on CKQ_CE. DTAC then falls on the first NCK12_CE with CKE=CKQ=1 sampled.

Edge cases:
- When strobes coincide, each flop uses its own strobe; all flops sample the same-edge (old) values.
- AS rising mid-wait aborts the cycle with no stale acknowledge on the next cycle.
- Reset mid-cycle: all outputs return high; the selects follow AS.

Decomposition:
- Package aliens_bus_pkg: region base/limit constants (ROM, BANK, bank-0, work, I/O, 051937, 051960, video window).
- One combinational sub-module, aliens_addr_decode: ADRF3/AS/BK4/INIT/WOCO/RMRD in; the seven selects plus fast_n and vid_n out.
- Top level holds s1, s2, dtac_q and the DTAC logic.

Test Plan:
- Reset: nRESET=0 with AS=0, A=0x8000 -> DTAC=1 and s1=s2=dtac_q=1 while reset is held; after release, PROG=0.
- ROM read: AS falls at A=0x9000 -> PROG=0, other selects high; DTAC=0 after the next CK12_CE then NCK12_CE; DTAC=1 in the same cycle AS rises.
- Bank-0 toggle: A=0x0100, BK4=1 -> CRAMCS=0; BK4=0, WOCO=1 -> WORK=0; WOCO=0 -> no select, DTAC still acknowledges.
- I/O: A=0x5F88 -> IOCS=0, VRAMCS=1; fast DTAC.
- Video wait: A=0x4000 with CKE=CKQ=0 -> VRAMCS=0, DTAC stays 1; after CKQ_CE and an NCK12_CE with CKE=CKQ=1 -> DTAC=0.
- OBJ/RMRD: A=0x7C10 -> OBJCS=0 with RMRD=0; with RMRD=1 -> VRAMCS=0 and OBJCS=1. INIT=1 -> all selects high and DTAC still asserts.

Source files
------------

// File: rtl/aliens_bus_pkg.sv
// ---------------------------------------------------------------------------
// aliens_bus_pkg
// Purpose : Fixed memory map of the Aliens main CPU (Konami-2) bus.
//           All region constants are word addresses on ADRF3 = A[15:3],
//           so each byte range 0xLLLL-0xHHHH appears here as LLLL>>3 .. HHHH>>3.
// Contents: region_t (inclusive base/limit pair), one constant per decoded
//           region and the in_region() helper used by the decoder.
// ---------------------------------------------------------------------------
package aliens_bus_pkg;

    typedef struct packed {
        logic [12:0] base;
        logic [12:0] limit;
    } region_t;

    // Program ROM, 0x8000-0xFFFF
    localparam region_t ROM_REGION     = '{base: 13'h1000, limit: 13'h1FFF};
    // Banked ROM window, 0x2000-0x3FFF
    localparam region_t BANK_REGION    = '{base: 13'h0400, limit: 13'h07FF};
    // Bank-0 window shared by palette and work RAM, 0x0000-0x03FF
    localparam region_t BANK0_REGION   = '{base: 13'h0000, limit: 13'h007F};
    // Work RAM proper, 0x0400-0x1FFF
    localparam region_t WORK_REGION    = '{base: 13'h0080, limit: 13'h03FF};
    // I/O registers, 0x5F80-0x5F9F
    localparam region_t IO_REGION      = '{base: 13'h0BF0, limit: 13'h0BF3};
    // K051937 control registers, 0x7800-0x7807
    localparam region_t K051937_REGION = '{base: 13'h0F00, limit: 13'h0F00};
    // K051960 sprite RAM, 0x7C00-0x7FFF
    localparam region_t K051960_REGION = '{base: 13'h0F80, limit: 13'h0FFF};
    // Whole video-chip window, 0x4000-0x7FFF
    localparam region_t VID_REGION     = '{base: 13'h0800, limit: 13'h0FFF};

    function automatic logic in_region(input logic [12:0] adr, input region_t r);
        return (adr >= r.base) && (adr <= r.limit);
    endfunction

endpackage

// File: rtl/aliens_addr_decode.sv
// ---------------------------------------------------------------------------
// aliens_addr_decode
// Purpose : Purely combinational address decode for the Aliens main CPU bus.
// Inputs  : ADRF3 (A[15:3]), AS (active low), BK4 (palette/work bank-0 select),
//           INIT (suppresses selects), WOCO (work-RAM enable), RMRD (video ROM
//           read mode, hands the object window to the K052109).
// Outputs : PROG, BANK, WORK, CRAMCS, VRAMCS, OBJCS, IOCS (all active low),
//           fast_n (non-video cycle), vid_n (video-chip cycle needing a wait).
// ---------------------------------------------------------------------------
module aliens_addr_decode
    import aliens_bus_pkg::*;
(
    input  logic [12:0] ADRF3,
    input  logic        AS,
    input  logic        BK4,
    input  logic        INIT,
    input  logic        WOCO,
    input  logic        RMRD,
    output logic        PROG,
    output logic        BANK,
    output logic        WORK,
    output logic        CRAMCS,
    output logic        VRAMCS,
    output logic        OBJCS,
    output logic        IOCS,
    output logic        fast_n,
    output logic        vid_n
);

    logic cycle_on;
    logic hit_rom;
    logic hit_bank;
    logic hit_bank0;
    logic hit_work;
    logic hit_io;
    logic hit_obj;
    logic hit_vid;

    // Region hits are independent of AS/INIT; the select qualification is
    // applied afterwards so the region flags below can ignore INIT.
    always_comb begin
        hit_rom   = in_region(ADRF3, ROM_REGION);
        hit_bank  = in_region(ADRF3, BANK_REGION);
        hit_bank0 = in_region(ADRF3, BANK0_REGION);
        hit_work  = in_region(ADRF3, WORK_REGION);
        hit_io    = in_region(ADRF3, IO_REGION);
        hit_vid   = in_region(ADRF3, VID_REGION);
        // With RMRD set the K052109 owns the object window for ROM readback.
        hit_obj   = !RMRD && (in_region(ADRF3, K051937_REGION) ||
                              in_region(ADRF3, K051960_REGION));
    end

    // Active-low selects. VRAMCS takes whatever is left of the video window
    // once the I/O and object holes are carved out.
    always_comb begin
        cycle_on = !AS && !INIT;
        PROG     = !(cycle_on && hit_rom);
        BANK     = !(cycle_on && hit_bank);
        CRAMCS   = !(cycle_on && hit_bank0 && BK4);
        WORK     = !(cycle_on && WOCO && (hit_work || (hit_bank0 && !BK4)));
        IOCS     = !(cycle_on && hit_io);
        OBJCS    = !(cycle_on && hit_obj);
        VRAMCS   = !(cycle_on && hit_vid && !hit_io && !hit_obj);
    end

    // fast_n ignores INIT/WOCO on purpose: an unselected non-video access
    // must still be acknowledged or the CPU would hang. vid_n keys off the
    // qualified IOCS, so an I/O address under INIT is treated as video.
    always_comb begin
        fast_n = !(!AS && !hit_vid);
        vid_n  = !(!AS && hit_vid && IOCS);
    end

endmodule

// File: rtl/aliens_bus_ctrl.sv
// ---------------------------------------------------------------------------
// aliens_bus_ctrl
// Purpose : Aliens main CPU bus controller: address decode plus the DTAC
//           wait-state generator that aligns video-chip cycles to CKE/CKQ.
// Inputs  : SYSCLK, nRESET (async, active low), CK12_CE / NCK12_CE / CKQ_CE
//           (single-SYSCLK phase strobes), CKE, CKQ (CPU phase levels),
//           AS, ADRF3, BK4, INIT, WOCO, RMRD.
// Outputs : PROG, BANK, WORK, CRAMCS, VRAMCS, OBJCS, IOCS (active-low
//           selects) and DTAC (active-low data acknowledge).
// ---------------------------------------------------------------------------
module aliens_bus_ctrl
    import aliens_bus_pkg::*;
(
    input  logic        SYSCLK,
    input  logic        nRESET,
    input  logic        CK12_CE,
    input  logic        NCK12_CE,
    input  logic        CKQ_CE,
    input  logic        CKE,
    input  logic        CKQ,
    input  logic        AS,
    input  logic [12:0] ADRF3,
    input  logic        BK4,
    input  logic        INIT,
    input  logic        WOCO,
    input  logic        RMRD,
    output logic        PROG,
    output logic        BANK,
    output logic        WORK,
    output logic        CRAMCS,
    output logic        VRAMCS,
    output logic        OBJCS,
    output logic        IOCS,
    output logic        DTAC
);

    logic fast_n;
    logic vid_n;
    logic s1;
    logic s2;
    logic dtac_q;
    logic vrdy_n;
    logic d_next;

    aliens_addr_decode u_decode (
        .ADRF3  (ADRF3),
        .AS     (AS),
        .BK4    (BK4),
        .INIT   (INIT),
        .WOCO   (WOCO),
        .RMRD   (RMRD),
        .PROG   (PROG),
        .BANK   (BANK),
        .WORK   (WORK),
        .CRAMCS (CRAMCS),
        .VRAMCS (VRAMCS),
        .OBJCS  (OBJCS),
        .IOCS   (IOCS),
        .fast_n (fast_n),
        .vid_n  (vid_n)
    );

    // A video cycle is ready once s1 has seen it on a CKQ edge; the ack
    // may then drop only while both CPU phases are high. s2 low marks a
    // fast (non-video or I/O) cycle, which forces the ack unconditionally.
    always_comb begin
        vrdy_n = s1 | vid_n;
        d_next = s2 & (~(CKE & CKQ) | vrdy_n);
    end

    // The three handshake flops. Each advances only on its own phase
    // strobe, so coincident strobes all see the pre-edge values. AS high
    // clears everything so an aborted cycle leaves nothing behind.
    always_ff @(posedge SYSCLK or negedge nRESET) begin
        if (!nRESET) begin
            s1     <= 1'b1;
            s2     <= 1'b1;
            dtac_q <= 1'b1;
        end else if (AS) begin
            s1     <= 1'b1;
            s2     <= 1'b1;
            dtac_q <= 1'b1;
        end else begin
            if (CKQ_CE) begin
                s1 <= vid_n;
            end
            if (CK12_CE) begin
                s2 <= fast_n & IOCS;
            end
            if (NCK12_CE) begin
                dtac_q <= d_next;
            end
        end
    end

    // Gating with AS releases the ack in the same cycle the strobe rises.
    always_comb begin
        DTAC = dtac_q | AS;
    end

endmodule

// File: tb/tb_aliens_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aliens_bus_ctrl
// Purpose : Self-checking bench for aliens_bus_ctrl: a table of decode
//           vectors followed by hand-written DTAC handshake sequences.
// ---------------------------------------------------------------------------
module tb_aliens_bus_ctrl;

    logic        SYSCLK;
    logic        nRESET;
    logic        CK12_CE;
    logic        NCK12_CE;
    logic        CKQ_CE;
    logic        CKE;
    logic        CKQ;
    logic        AS;
    logic [12:0] ADRF3;
    logic        BK4;
    logic        INIT;
    logic        WOCO;
    logic        RMRD;
    logic        PROG;
    logic        BANK;
    logic        WORK;
    logic        CRAMCS;
    logic        VRAMCS;
    logic        OBJCS;
    logic        IOCS;
    logic        DTAC;

    int checkCount = 0;
    int passCount  = 0;

    // Select vector order: {PROG, BANK, WORK, CRAMCS, VRAMCS, OBJCS, IOCS}
    localparam logic [6:0] SEL_NONE = 7'b1111111;
    localparam logic [6:0] SEL_PROG = 7'b0111111;
    localparam logic [6:0] SEL_BANK = 7'b1011111;
    localparam logic [6:0] SEL_WORK = 7'b1101111;
    localparam logic [6:0] SEL_CRAM = 7'b1110111;
    localparam logic [6:0] SEL_VRAM = 7'b1111011;
    localparam logic [6:0] SEL_OBJ  = 7'b1111101;
    localparam logic [6:0] SEL_IO   = 7'b1111110;

    typedef struct {
        logic [15:0] addr;
        logic        as;
        logic        bk4;
        logic        woco;
        logic        rmrd;
        logic        init;
        logic [6:0]  expSel;
    } vec_t;

    vec_t vecs[$];

    aliens_bus_ctrl dut (
        .SYSCLK   (SYSCLK),
        .nRESET   (nRESET),
        .CK12_CE  (CK12_CE),
        .NCK12_CE (NCK12_CE),
        .CKQ_CE   (CKQ_CE),
        .CKE      (CKE),
        .CKQ      (CKQ),
        .AS       (AS),
        .ADRF3    (ADRF3),
        .BK4      (BK4),
        .INIT     (INIT),
        .WOCO     (WOCO),
        .RMRD     (RMRD),
        .PROG     (PROG),
        .BANK     (BANK),
        .WORK     (WORK),
        .CRAMCS   (CRAMCS),
        .VRAMCS   (VRAMCS),
        .OBJCS    (OBJCS),
        .IOCS     (IOCS),
        .DTAC     (DTAC)
    );

    initial begin
        SYSCLK = 1'b0;
        forever #5 SYSCLK = ~SYSCLK;
    end

    task automatic addVec(input logic [15:0] addr, input logic as, input logic bk4,
                          input logic woco, input logic rmrd, input logic init,
                          input logic [6:0] expSel);
        vec_t v;
        v.addr   = addr;
        v.as     = as;
        v.bk4    = bk4;
        v.woco   = woco;
        v.rmrd   = rmrd;
        v.init   = init;
        v.expSel = expSel;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        ADRF3 = v.addr[15:3];
        AS    = v.as;
        BK4   = v.bk4;
        WOCO  = v.woco;
        RMRD  = v.rmrd;
        INIT  = v.init;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One SYSCLK with the given phase strobes held across the rising edge;
    // outputs are then stable 1 time unit after the edge.
    task automatic cycle(input logic ck12, input logic nck12, input logic ckq);
        CK12_CE  = ck12;
        NCK12_CE = nck12;
        CKQ_CE   = ckq;
        @(posedge SYSCLK);
        #1;
        CK12_CE  = 1'b0;
        NCK12_CE = 1'b0;
        CKQ_CE   = 1'b0;
    endtask

    task automatic startCycle(input logic [15:0] addr);
        ADRF3 = addr[15:3];
        AS    = 1'b0;
        #1;
    endtask

    task automatic endCycle();
        AS = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [6:0] selNow();
        return {PROG, BANK, WORK, CRAMCS, VRAMCS, OBJCS, IOCS};
    endfunction

    initial begin
        nRESET = 1'b1;
        CK12_CE = 1'b0; NCK12_CE = 1'b0; CKQ_CE = 1'b0;
        CKE = 1'b0; CKQ = 1'b0;
        AS = 1'b1; ADRF3 = '0; BK4 = 1'b0; INIT = 1'b0; WOCO = 1'b1; RMRD = 1'b0;

        // ---------------- reset ----------------
        $display("[TB] reset");
        ADRF3 = 13'h1000;
        AS = 1'b0;
        #2 nRESET = 1'b0;
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        checkOutput("reset DTAC", DTAC, 1);
        checkOutput("reset s1", dut.s1, 1);
        checkOutput("reset s2", dut.s2, 1);
        checkOutput("reset dtac_q", dut.dtac_q, 1);
        nRESET = 1'b1;
        #1;
        checkOutput("post-reset PROG", PROG, 0);
        endCycle();

        // ---------------- decode table ----------------
        //      addr      as  bk4 woco rmrd init expected
        addVec(16'h9000, 0, 0, 1, 0, 0, SEL_PROG);
        addVec(16'h8000, 0, 0, 1, 0, 0, SEL_PROG);
        addVec(16'hFFFF, 0, 0, 1, 0, 0, SEL_PROG);
        addVec(16'h2000, 0, 0, 1, 0, 0, SEL_BANK);
        addVec(16'h3FFF, 0, 0, 1, 0, 0, SEL_BANK);
        addVec(16'h0100, 0, 1, 1, 0, 0, SEL_CRAM);
        addVec(16'h0100, 0, 0, 1, 0, 0, SEL_WORK);
        addVec(16'h0100, 0, 0, 0, 0, 0, SEL_NONE);
        addVec(16'h03FF, 0, 1, 0, 0, 0, SEL_CRAM);
        addVec(16'h0400, 0, 1, 1, 0, 0, SEL_WORK);
        addVec(16'h1FFF, 0, 0, 1, 0, 0, SEL_WORK);
        addVec(16'h1FFF, 0, 0, 0, 0, 0, SEL_NONE);
        addVec(16'h4000, 0, 0, 1, 0, 0, SEL_VRAM);
        addVec(16'h5F7F, 0, 0, 1, 0, 0, SEL_VRAM);
        addVec(16'h5F80, 0, 0, 1, 1, 0, SEL_IO);
        addVec(16'h5F88, 0, 0, 1, 0, 0, SEL_IO);
        addVec(16'h5F9F, 0, 0, 1, 0, 0, SEL_IO);
        addVec(16'h5FA0, 0, 0, 1, 0, 0, SEL_VRAM);
        addVec(16'h7800, 0, 0, 1, 0, 0, SEL_OBJ);
        addVec(16'h7807, 0, 0, 1, 0, 0, SEL_OBJ);
        addVec(16'h7808, 0, 0, 1, 0, 0, SEL_VRAM);
        addVec(16'h7BFF, 0, 0, 1, 0, 0, SEL_VRAM);
        addVec(16'h7C10, 0, 0, 1, 0, 0, SEL_OBJ);
        addVec(16'h7C10, 0, 0, 1, 1, 0, SEL_VRAM);
        addVec(16'h7800, 0, 0, 1, 1, 0, SEL_VRAM);
        addVec(16'h7FFF, 0, 0, 1, 0, 0, SEL_OBJ);
        addVec(16'h9000, 0, 0, 1, 0, 1, SEL_NONE);
        addVec(16'h7C10, 0, 0, 1, 0, 1, SEL_NONE);
        addVec(16'h9000, 1, 0, 1, 0, 0, SEL_NONE);
        addVec(16'h5F88, 1, 0, 1, 0, 0, SEL_NONE);

        $display("[TB] decode table, %0d vectors", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("decode[%0d] %04h", i, vecs[i].addr),
                        32'(selNow()), 32'(vecs[i].expSel));
        end
        BK4 = 1'b0; WOCO = 1'b1; RMRD = 1'b0; INIT = 1'b0;
        endCycle();

        // ---------------- ROM read, fast ack ----------------
        $display("[TB] ROM read");
        startCycle(16'h9000);
        cycle(1'b0, 1'b1, 1'b0);
        checkOutput("rom early NCK12 DTAC", DTAC, 1);
        cycle(1'b1, 1'b0, 1'b0);
        checkOutput("rom after CK12 DTAC", DTAC, 1);
        cycle(1'b0, 1'b1, 1'b0);
        checkOutput("rom ack DTAC", DTAC, 0);
        AS = 1'b1;
        #1;
        checkOutput("rom release DTAC", DTAC, 1);
        cycle(1'b0, 1'b0, 1'b0);

        // ---------------- bank-0 with WOCO=0 still acks ----------------
        $display("[TB] bank-0 unselected");
        WOCO = 1'b0;
        startCycle(16'h0100);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        checkOutput("bank0 woco0 DTAC", DTAC, 0);
        WOCO = 1'b1;
        endCycle();

        // ---------------- INIT suppresses selects, not ack ----------------
        $display("[TB] INIT cycle");
        INIT = 1'b1;
        startCycle(16'h9000);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        checkOutput("init selects", 32'(selNow()), 32'(SEL_NONE));
        checkOutput("init DTAC", DTAC, 0);
        INIT = 1'b0;
        endCycle();

        // ---------------- I/O is fast ----------------
        $display("[TB] I/O");
        startCycle(16'h5F88);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        checkOutput("io DTAC", DTAC, 0);
        endCycle();

        // ---------------- video wait ----------------
        $display("[TB] video wait");
        startCycle(16'h4000);
        checkOutput("video VRAMCS", VRAMCS, 0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        checkOutput("video no s1 DTAC", DTAC, 1);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        checkOutput("video phase low DTAC", DTAC, 1);
        CKE = 1'b1; CKQ = 1'b1;
        cycle(1'b0, 1'b1, 1'b0);
        checkOutput("video ack DTAC", DTAC, 0);
        endCycle();

        // Phases high but no CKQ capture yet: must keep waiting.
        startCycle(16'h4000);
        cycle(1'b1, 1'b1, 1'b0);
        checkOutput("video uncaptured DTAC", DTAC, 1);
        endCycle();

        // ---------------- abort mid-wait ----------------
        $display("[TB] abort");
        CKE = 1'b0; CKQ = 1'b0;
        startCycle(16'h7C10);
        cycle(1'b1, 1'b0, 1'b1);
        AS = 1'b1;
        #1;
        checkOutput("abort DTAC", DTAC, 1);
        cycle(1'b0, 1'b0, 1'b0);
        CKE = 1'b1; CKQ = 1'b1;
        startCycle(16'h7C10);
        cycle(1'b0, 1'b1, 1'b0);
        checkOutput("post-abort stale DTAC", DTAC, 1);
        CKE = 1'b0; CKQ = 1'b0;
        endCycle();

        // ---------------- coincident strobes ----------------
        $display("[TB] coincident strobes");
        startCycle(16'h9000);
        cycle(1'b1, 1'b1, 1'b0);
        checkOutput("coincident DTAC", DTAC, 1);
        cycle(1'b0, 1'b1, 1'b0);
        checkOutput("coincident next DTAC", DTAC, 0);

        // ---------------- reset mid-cycle ----------------
        $display("[TB] reset mid-cycle");
        nRESET = 1'b0;
        #1;
        checkOutput("midreset DTAC", DTAC, 1);
        checkOutput("midreset PROG", PROG, 0);
        nRESET = 1'b1;
        endCycle();

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
